// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO geometry and pointer-width helper.
package fifo_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage, one write port and one registered read port, no reset.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy counter, status flags and sticky error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     w_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     r_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic [$clog2(DEPTH):0]   counter,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: WIDTH must be at least 1");
    end

    logic [AW-1:0]    w_ptr, r_ptr;
    logic [WIDTH-1:0] mem_q;
    logic             wr_ok, rd_ok, out_live;

    assign full         = counter == FULL_CNT;
    assign empty        = counter == '0;
    assign almost_full  = counter >= AF_CNT;
    assign almost_empty = counter <= AE_CNT;
    assign wr_ok        = reset_n & ~clr & w_en & ~full;
    assign rd_ok        = reset_n & ~clr & r_en & ~empty;
    // Storage has no reset, so data_out reads as zero until the first read after reset.
    assign data_out     = out_live ? mem_q : '0;

    fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (w_ptr),
        .wdata (data_in),
        .re    (rd_ok),
        .raddr (r_ptr),
        .rdata (mem_q)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_ptr      <= '0;
            r_ptr      <= '0;
            counter    <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            out_live   <= 1'b0;
        end else if (clr) begin
            w_ptr      <= '0;
            r_ptr      <= '0;
            counter    <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            w_ptr      <= w_ptr + AW'(wr_ok);
            r_ptr      <= r_ptr + AW'(rd_ok);
            counter    <= counter + CW'(wr_ok) - CW'(rd_ok);
            data_valid <= rd_ok;
            overflow   <= overflow | (w_en & full);
            underflow  <= underflow | (r_en & empty);
            out_live   <= out_live | rd_ok;
        end
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed and random stimulus checked against a queue-based FIFO model.
module tb_sync_fifo_param;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0, clr = 1'b0, w_en = 1'b0, r_en = 1'b0;
    logic [7:0] data_in = '0, data_out;
    logic       data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] counter;

    sync_fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .data_valid(data_valid), .counter(counter), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_dv, m_ov, m_un;
    int         n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c = 1'b0, input logic rn = 1'b1);
        int  sz;
        logic m_full, m_empty;
        @(negedge clk);
        w_en = w; data_in = d; r_en = r; clr = c; reset_n = rn;
        @(posedge clk);
        sz = q.size();
        m_full = sz == DEPTH;
        m_empty = sz == 0;
        if (!rn) begin
            q.delete(); m_dout = 8'h00; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else if (c) begin
            q.delete(); m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else begin
            if (w && m_full) m_ov = 1'b1;
            if (r && m_empty) m_un = 1'b1;
            m_dv = r && !m_empty;
            if (m_dv) m_dout = q.pop_front();
            if (w && !m_full) q.push_back(d);
        end
        #1;
        sz = q.size();
        check("counter", 32'(counter), 32'(sz));
        check("full", 32'(full), 32'(sz == DEPTH));
        check("empty", 32'(empty), 32'(sz == 0));
        check("almost_full", 32'(almost_full), 32'(sz >= AFL));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AEL));
        check("data_valid", 32'(data_valid), 32'(m_dv));
        check("data_out", 32'(data_out), 32'(m_dout));
        check("overflow", 32'(overflow), 32'(m_ov));
        check("underflow", 32'(underflow), 32'(m_un));
    endtask

    initial begin
        logic phase;
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("rst_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 12) check("af_before_14", 32'(almost_full), 32'd0);
            if (i == 13) check("af_after_14", 32'(almost_full), 32'd1);
        end
        check("full_cnt", 32'(counter), 32'd16);
        step(1'b1, 8'hEE, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("rd_order", 32'(data_out), 32'(i));
        end
        step(1'b0, 8'h00, 1'b1);
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_dout_hold", 32'(data_out), 32'h0F);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("wrap_data", 32'(data_out), 32'(8'hA0 + i));
        end
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1);
        check("simul_cnt", 32'(counter), 32'd5);
        for (int i = 0; i < 11; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'h77, 1'b1);
        check("full_rw_cnt", 32'(counter), 32'd15);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b1);
        check("clr_cnt", 32'(counter), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), i > 2);
        step(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
        check("rst_mid_dout", 32'(data_out), 32'd0);
        phase = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 48 == 0) phase = ~phase;
            step($urandom_range(0, 9) < (phase ? 8 : 3), 8'($urandom),
                 $urandom_range(0, 9) < (phase ? 3 : 8),
                 $urandom_range(0, 99) == 0, $urandom_range(0, 299) != 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
